// File: rtl/activation_pkg.sv
// activation_pkg: shared mode/segment types and fixed-point helpers
// for the activation_multi_mode pipeline.
package activation_pkg;

  typedef enum logic [1:0] {
    ACT_BYPASS  = 2'b00,
    ACT_RELU    = 2'b01,
    ACT_TANH    = 2'b10,
    ACT_SIGMOID = 2'b11
  } act_mode_e;

  typedef enum logic [1:0] {
    SEG_LOW  = 2'b00,
    SEG_MID  = 2'b01,
    SEG_HIGH = 2'b10
  } seg_e;

  localparam int DEF_FRAC_BITS = 4;

  function automatic int fx_one(input int frac);
    return 1 << frac;
  endfunction

  function automatic int fx_half(input int frac);
    return 1 << (frac - 1);
  endfunction

  function automatic int fx_quarter(input int frac);
    return 1 << (frac - 2);
  endfunction

endpackage

// File: rtl/activation_multi_mode_if.sv
// activation_multi_mode_if: input/output beat streams with
// valid/ready handshake plus job/mode sideband.
interface activation_multi_mode_if #(
  parameter int NUM_LANES = 16,
  parameter int DWIDTH    = 8,
  parameter int CNT_W     = 16
);

  logic                        enable_activation;
  logic [1:0]                  activation_type;
  logic [CNT_W-1:0]            num_vectors;
  logic                        in_data_available;
  logic                        in_ready;
  logic [NUM_LANES*DWIDTH-1:0] inp_data;
  logic [NUM_LANES-1:0]        validity_mask;
  logic [NUM_LANES*DWIDTH-1:0] out_data;
  logic                        out_data_available;
  logic                        out_ready;
  logic                        done_activation;

  modport master (
    output enable_activation,
    output activation_type,
    output num_vectors,
    output in_data_available,
    input  in_ready,
    output inp_data,
    output validity_mask,
    input  out_data,
    input  out_data_available,
    output out_ready,
    input  done_activation
  );

  modport slave (
    input  enable_activation,
    input  activation_type,
    input  num_vectors,
    input  in_data_available,
    output in_ready,
    input  inp_data,
    input  validity_mask,
    output out_data,
    output out_data_available,
    input  out_ready,
    output done_activation
  );

endinterface

// File: rtl/activation_multi_mode_lane.sv
// act_lane: one lane of the S2 datapath (mode, x, |x|, segment, mask -> y).
// ACT_LEAKY_RELU_EN makes ReLU pass x>>>3 for negative inputs.
module act_lane
  import activation_pkg::*;
#(
  parameter int DWIDTH    = 8,
  parameter int FRAC_BITS = 4
) (
  input  act_mode_e                i_mode,
  input  logic signed [DWIDTH-1:0] i_x,
  input  logic [DWIDTH-1:0]        i_ax,
  input  seg_e                     i_seg,
  input  logic                     i_mask,
  output logic [DWIDTH-1:0]        o_y
);

  localparam int W = DWIDTH + 2;

  localparam logic signed [W-1:0] ONE_W =
    W'(fx_one(FRAC_BITS));
  localparam logic signed [W-1:0] HALF_W =
    W'(fx_half(FRAC_BITS));
  localparam logic signed [W-1:0] QUART_W =
    W'(fx_quarter(FRAC_BITS));
  localparam logic signed [W-1:0] MAX_W =
    W'((1 << (DWIDTH - 1)) - 1);
  localparam logic signed [W-1:0] MIN_W = ~MAX_W;

  logic signed [W-1:0] w_x;
  logic signed [W-1:0] w_ax;
  logic signed [W-1:0] w_mag;
  logic signed [W-1:0] w_res;

  always_comb begin
    w_x   = {{2{i_x[DWIDTH-1]}}, i_x};
    w_ax  = {2'b00, i_ax};
    w_mag = w_ax;
    w_res = w_x;

    // tanh magnitude from the segment chosen in S1
    unique case (i_seg)
      SEG_MID:  w_mag = (w_ax >>> 1) + QUART_W;
      SEG_HIGH: w_mag = ONE_W;
      default:  w_mag = w_ax;
    endcase

    unique case (i_mode)
      ACT_BYPASS: w_res = w_x;
      ACT_RELU: begin
        if (!i_x[DWIDTH-1]) begin
          w_res = w_x;
        end else begin
`ifdef ACT_LEAKY_RELU_EN
          w_res = w_x >>> 3;
`else
          w_res = '0;
`endif
        end
      end
      ACT_TANH: begin
        w_res = i_x[DWIDTH-1] ? -w_mag : w_mag;
      end
      ACT_SIGMOID: begin
        unique case (i_seg)
          SEG_LOW:  w_res = '0;
          SEG_HIGH: w_res = ONE_W;
          default:  w_res = HALF_W + (w_x >>> 3);
        endcase
      end
      default: w_res = w_x;
    endcase

    if (w_res > MAX_W) begin
      w_res = MAX_W;
    end else if (w_res < MIN_W) begin
      w_res = MIN_W;
    end

    o_y = i_mask ? w_res[DWIDTH-1:0] : '0;
  end

endmodule

// File: rtl/activation_multi_mode.sv
// activation_multi_mode: 2-stage valid/ready activation pipeline with
// job counter and done pulse. ACT_LEAKY_RELU_EN selects leaky ReLU.
module activation_multi_mode
  import activation_pkg::*;
#(
  parameter int NUM_LANES = 16,
  parameter int DWIDTH    = 8,
  parameter int FRAC_BITS = 4,
  parameter int CNT_W     = 16
) (
  input logic                   clk,
  input logic                   reset,
  activation_multi_mode_if.slave bus
);

  localparam int ONE  = fx_one(FRAC_BITS);
  localparam int HALF = fx_half(FRAC_BITS);

  localparam logic signed [DWIDTH-1:0] X_MIN =
    {1'b1, {(DWIDTH-1){1'b0}}};
  localparam logic [DWIDTH-1:0] AX_MAX =
    {1'b0, {(DWIDTH-1){1'b1}}};

  logic                        w_stall;
  logic                        w_accept;
  logic                        w_out_xfer;
  act_mode_e                   w_mode;
  logic [CNT_W-1:0]            w_nv;
  logic                        w_last;
  logic [NUM_LANES*DWIDTH-1:0] w_y;

  logic                        r_s1_valid;
  act_mode_e                   r_s1_mode;
  logic [NUM_LANES-1:0]        r_s1_mask;
  logic                        r_s1_last;

  logic                        r_out_valid;
  logic [NUM_LANES*DWIDTH-1:0] r_out_data;
  logic                        r_out_last;

  logic [CNT_W-1:0]            r_cnt;
  logic [CNT_W-1:0]            r_nv;

  assign w_stall      = r_out_valid && !bus.out_ready;
  assign bus.in_ready = !w_stall || !r_s1_valid;
  assign w_accept     = bus.in_data_available && bus.in_ready;
  assign w_out_xfer   = r_out_valid && bus.out_ready;

  assign bus.out_data           = r_out_data;
  assign bus.out_data_available = r_out_valid;
  assign bus.done_activation    = w_out_xfer && r_out_last;

  assign w_mode = bus.enable_activation ?
                  act_mode_e'(bus.activation_type) :
                  ACT_BYPASS;

  // job length is latched on the first beat of each job only
  always_comb begin
    w_nv = r_nv;
    if (r_cnt == '0) begin
      w_nv = (bus.num_vectors == '0) ?
             CNT_W'(1) : bus.num_vectors;
    end
    w_last = ({1'b0, r_cnt} + 1'b1) == {1'b0, w_nv};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_nv  <= '0;
    end else if (w_accept) begin
      r_nv  <= w_nv;
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_mode  <= ACT_BYPASS;
      r_s1_mask  <= '0;
      r_s1_last  <= 1'b0;
    end else if (bus.in_ready) begin
      r_s1_valid <= bus.in_data_available;
      if (w_accept) begin
        r_s1_mode <= w_mode;
        r_s1_mask <= bus.validity_mask;
        r_s1_last <= w_last;
      end
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic signed [DWIDTH-1:0] w_x;
    logic [DWIDTH-1:0]        w_ax;
    seg_e                     w_seg;
    logic signed [DWIDTH-1:0] r_x;
    logic [DWIDTH-1:0]        r_ax;
    seg_e                     r_seg;

    assign w_x  = bus.inp_data[g*DWIDTH +: DWIDTH];
    assign w_ax = (w_x == X_MIN) ? AX_MAX :
                  w_x[DWIDTH-1] ? $unsigned(-w_x) :
                  $unsigned(w_x);

    always_comb begin
      w_seg = SEG_LOW;
      unique case (w_mode)
        ACT_TANH: begin
          if (int'(w_ax) >= ONE + HALF) begin
            w_seg = SEG_HIGH;
          end else if (int'(w_ax) >= HALF) begin
            w_seg = SEG_MID;
          end
        end
        ACT_SIGMOID: begin
          unique case (1'b1)
            (int'(w_x) >= 4 * ONE):  w_seg = SEG_HIGH;
            (int'(w_x) <= -4 * ONE): w_seg = SEG_LOW;
            default:                 w_seg = SEG_MID;
          endcase
        end
        default: w_seg = SEG_LOW;
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        r_x   <= '0;
        r_ax  <= '0;
        r_seg <= SEG_LOW;
      end else if (w_accept) begin
        r_x   <= w_x;
        r_ax  <= w_ax;
        r_seg <= w_seg;
      end
    end

    act_lane #(
      .DWIDTH    (DWIDTH),
      .FRAC_BITS (FRAC_BITS)
    ) u_lane (
      .i_mode (r_s1_mode),
      .i_x    (r_x),
      .i_ax   (r_ax),
      .i_seg  (r_seg),
      .i_mask (r_s1_mask[g]),
      .o_y    (w_y[g*DWIDTH +: DWIDTH])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else if (!w_stall) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data <= w_y;
        r_out_last <= r_s1_last;
      end
    end
  end

endmodule

// File: tb/tb_activation_multi_mode.sv
// tb_activation_multi_mode: table vectors, hand-written corner sequences
// and a random run scored against an arithmetic lane model.
module tb_activation_multi_mode;

  localparam int NL  = 16;
  localparam int DW  = 8;
  localparam int FB  = 4;
  localparam int CW  = 16;
  localparam int VW  = NL * DW;
  localparam int ONE = 1 << FB;

`ifdef ACT_LEAKY_RELU_EN
  localparam logic [7:0] RELU_F0 = 8'hFE;
  localparam logic [7:0] RELU_80 = 8'hF0;
`else
  localparam logic [7:0] RELU_F0 = 8'h00;
  localparam logic [7:0] RELU_80 = 8'h00;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  activation_multi_mode_if #(
    .NUM_LANES (NL),
    .DWIDTH    (DW),
    .CNT_W     (CW)
  ) bus ();

  activation_multi_mode #(
    .NUM_LANES (NL),
    .DWIDTH    (DW),
    .FRAC_BITS (FB),
    .CNT_W     (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [VW-1:0] data;
    bit            last;
  } beat_t;

  typedef struct {
    logic [1:0]    mode;
    bit            en;
    logic [NL-1:0] mask;
    logic [VW-1:0] din;
    logic [VW-1:0] dexp;
  } vec_t;

  beat_t sb[$];
  vec_t  tv[$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int n_out    = 0;
  int m_cnt    = 0;
  int m_nv     = 1;

  logic [31:0]   done_hist = '0;
  logic [VW-1:0] s_out;
  bit            s_ov, s_done, s_ir;

  task automatic chk(input string name,
                     input logic [VW-1:0] got,
                     input logic [VW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               name, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s t=%0t", name, $time);
  endtask

  function automatic int fdiv8(input int v);
    return (v - (((v % 8) + 8) % 8)) / 8;
  endfunction

  function automatic int ref_lane(input int mode,
                                  input logic [7:0] raw);
    int x, ax, r;
    x  = int'($signed(raw));
    ax = (x < 0) ? -x : x;
    if (ax > 127) ax = 127;
    case (mode)
      1: begin
        r = (x > 0) ? x : 0;
`ifdef ACT_LEAKY_RELU_EN
        if (x < 0) r = fdiv8(x);
`endif
      end
      2: begin
        if (ax < ONE / 2)          r = ax;
        else if (ax < 3 * ONE / 2) r = ax / 2 + ONE / 4;
        else                       r = ONE;
        if (x < 0) r = -r;
      end
      3: begin
        if (x >= 4 * ONE)       r = ONE;
        else if (x <= -4 * ONE) r = 0;
        else                    r = ONE / 2 + fdiv8(x);
      end
      default: r = x;
    endcase
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
    return r;
  endfunction

  function automatic logic [VW-1:0] ref_vec(
      input logic [1:0] mode, input bit en,
      input logic [NL-1:0] mask,
      input logic [VW-1:0] d);
    logic [VW-1:0] o;
    int md, y;
    o  = '0;
    md = en ? int'(mode) : 0;
    for (int i = 0; i < NL; i++) begin
      y = mask[i] ? ref_lane(md, d[i*DW +: DW]) : 0;
      o[i*DW +: DW] = 8'(y);
    end
    return o;
  endfunction

  function automatic logic [VW-1:0] vec(input logic [7:0] l0,
                                        input logic [7:0] rest);
    return {{(NL-1){rest}}, l0};
  endfunction

  task automatic add(input logic [1:0] mode, input bit en,
                     input logic [NL-1:0] mask,
                     input logic [VW-1:0] din,
                     input logic [VW-1:0] dexp);
    vec_t v;
    v.mode = mode;
    v.en   = en;
    v.mask = mask;
    v.din  = din;
    v.dexp = dexp;
    tv.push_back(v);
  endtask

  task automatic model_accept();
    beat_t b;
    int nv;
    nv = int'(bus.num_vectors);
    if (nv == 0) nv = 1;
    if (m_cnt == 0) m_nv = nv;
    m_cnt++;
    b.last = (m_cnt == m_nv);
    if (b.last) m_cnt = 0;
    b.data = ref_vec(bus.activation_type, bus.enable_activation,
                     bus.validity_mask, bus.inp_data);
    sb.push_back(b);
    n_acc++;
  endtask

  // one clock: called at a negedge with inputs already set
  task automatic cycle();
    beat_t e;
    bit exp_ir;
    #1;
    exp_ir = !(bus.out_data_available && !bus.out_ready &&
               sb.size() >= 2);
    chk("in_ready", VW'(bus.in_ready), VW'(exp_ir));
    s_ov   = bus.out_data_available;
    s_out  = bus.out_data;
    s_done = bus.done_activation;
    s_ir   = bus.in_ready;
    if (bus.out_data_available && bus.out_ready) begin
      if (sb.size() == 0) begin
        fail_now("spurious_out");
      end else begin
        e = sb.pop_front();
        chk("out_data", bus.out_data, e.data);
        chk("done", VW'(bus.done_activation), VW'(e.last));
        done_hist = {done_hist[30:0], bus.done_activation};
        n_out++;
      end
    end else begin
      chk("done_idle", VW'(bus.done_activation), VW'(1'b0));
    end
    if (bus.in_data_available && bus.in_ready) model_accept();
    @(negedge clk);
  endtask

  task automatic drain();
    bus.in_data_available = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() > 0; i++) cycle();
    if (sb.size() != 0) fail_now("drain_timeout");
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.in_data_available = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    m_cnt = 0;
  endtask

  function automatic logic [VW-1:0] pat(input int k);
    logic [VW-1:0] d;
    for (int i = 0; i < NL; i++) d[i*DW +: DW] = 8'(k * 16 + i);
    return d;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int base, obase;

    add(2'd2, 1, '1, vec(8'h10, 8'h00), vec(8'h0C, 8'h00));
    add(2'd2, 1, '1, vec(8'hF0, 8'h00), vec(8'hF4, 8'h00));
    add(2'd2, 1, '1, vec(8'h30, 8'h00), vec(8'h10, 8'h00));
    add(2'd2, 1, '1, vec(8'h05, 8'h00), vec(8'h05, 8'h00));
    add(2'd2, 1, '1, vec(8'h80, 8'h08), vec(8'hF0, 8'h08));
    add(2'd2, 1, '1, vec(8'h17, 8'h18), vec(8'h0F, 8'h10));
    add(2'd2, 1, '1, vec(8'h07, 8'hF8), vec(8'h07, 8'hF8));
    add(2'd3, 1, '1, vec(8'h00, 8'h00), vec(8'h08, 8'h08));
    add(2'd3, 1, '1, vec(8'h10, 8'h40), vec(8'h0A, 8'h10));
    add(2'd3, 1, '1, vec(8'h80, 8'hC0), vec(8'h00, 8'h00));
    add(2'd3, 1, '1, vec(8'h3F, 8'hF8), vec(8'h0F, 8'h07));
    add(2'd3, 1, '0, vec(8'h00, 8'h00), vec(8'h00, 8'h00));
    add(2'd1, 1, '1, vec(8'hF0, 8'h7F), vec(RELU_F0, 8'h7F));
    add(2'd1, 1, '1, vec(8'h01, 8'h80), vec(8'h01, RELU_80));
    add(2'd0, 1, 16'h00FF, vec(8'h7F, 8'h7F),
        {{8{8'h00}}, {8{8'h7F}}});
    add(2'd2, 0, '1, vec(8'h30, 8'h30), vec(8'h30, 8'h30));

    bus.enable_activation = 1'b1;
    bus.activation_type   = 2'd0;
    bus.num_vectors       = CW'(1);
    bus.in_data_available = 1'b0;
    bus.inp_data          = '0;
    bus.validity_mask     = '1;
    bus.out_ready         = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_data", bus.out_data, '0);
    chk("rst_out_valid", VW'(bus.out_data_available), VW'(1'b0));
    chk("rst_done", VW'(bus.done_activation), VW'(1'b0));
    chk("rst_in_ready", VW'(bus.in_ready), VW'(1'b1));
    @(negedge clk);
    reset = 1'b0;

    // table vectors: one-beat jobs, latency and value checks
    for (int i = 0; i < tv.size(); i++) begin
      bus.activation_type   = tv[i].mode;
      bus.enable_activation = tv[i].en;
      bus.validity_mask     = tv[i].mask;
      bus.inp_data          = tv[i].din;
      bus.num_vectors       = CW'(1);
      bus.in_data_available = 1'b1;
      bus.out_ready         = 1'b1;
      cycle();
      bus.in_data_available = 1'b0;
      cycle();
      chk("lat_gap", VW'(s_ov), VW'(1'b0));
      cycle();
      chk("lat_valid", VW'(s_ov), VW'(1'b1));
      chk($sformatf("vec%0d", i), s_out, tv[i].dexp);
      chk("vec_done", VW'(s_done), VW'(1'b1));
    end
    bus.enable_activation = 1'b1;
    bus.validity_mask     = '1;

    // random traffic with periodic long stalls
    for (int c = 0; c < 600; c++) begin
      bus.in_data_available = ($urandom % 4) != 0;
      bus.out_ready = (c % 50 < 10) ? 1'b0 : (($urandom % 4) != 0);
      bus.activation_type   = 2'($urandom);
      bus.enable_activation = ($urandom % 8) != 0;
      bus.validity_mask = ($urandom % 4 == 0) ? NL'($urandom) : '1;
      bus.num_vectors = CW'($urandom_range(0, 5));
      for (int l = 0; l < NL; l++)
        bus.inp_data[l*DW +: DW] = 8'($urandom);
      cycle();
    end
    drain();
    bus.enable_activation = 1'b1;
    bus.validity_mask     = '1;
    bus.activation_type   = 2'd0;

    // backpressure: 8-beat job, out_ready low in cycles 3-6
    do_reset();
    bus.num_vectors = CW'(8);
    base  = n_acc;
    obase = n_out;
    for (int c = 0; c < 40 && (n_acc - base) < 8; c++) begin
      bus.out_ready = !(c >= 3 && c <= 6);
      bus.in_data_available = 1'b1;
      bus.inp_data = pat(n_acc - base);
      cycle();
      if (c == 4) chk("bp_in_ready_low", VW'(s_ir), VW'(1'b0));
    end
    chk("bp_accepted", VW'(n_acc - base), VW'(8));
    drain();
    chk("bp_out_count", VW'(n_out - obase), VW'(8));
    chk("bp_done_hist", VW'(done_hist[7:0]), VW'(8'b0000_0001));

    // 8 back-to-back beats, job of 4; mid-job num_vectors ignored
    bus.out_ready = 1'b1;
    base = n_acc;
    for (int k = 0; k < 8; k++) begin
      bus.num_vectors = (k == 1 || k == 2) ? CW'(7) : CW'(4);
      bus.in_data_available = 1'b1;
      bus.inp_data = pat(k + 3);
      cycle();
    end
    chk("b2b_no_bubble", VW'(n_acc - base), VW'(8));
    drain();
    chk("nv4_done_hist", VW'(done_hist[7:0]), VW'(8'b0001_0001));

    bus.num_vectors = '0;
    for (int k = 0; k < 4; k++) begin
      bus.in_data_available = 1'b1;
      bus.inp_data = pat(k + 1);
      cycle();
    end
    drain();
    chk("nv0_done_hist", VW'(done_hist[3:0]), VW'(4'b1111));

    // reset with two beats in flight
    bus.num_vectors = CW'(5);
    bus.out_ready   = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.in_data_available = 1'b1;
      bus.inp_data = pat(k + 9);
      cycle();
    end
    do_reset();
    bus.out_ready = 1'b1;
    cycle();
    chk("rst_mid_valid", VW'(s_ov), VW'(1'b0));
    chk("rst_mid_data", s_out, '0);
    chk("rst_mid_done", VW'(s_done), VW'(1'b0));
    cycle();
    chk("rst_mid_valid2", VW'(s_ov), VW'(1'b0));
    obase = n_out;
    bus.num_vectors = CW'(1);
    bus.activation_type = 2'd2;
    bus.inp_data = vec(8'h10, 8'hF0);
    bus.in_data_available = 1'b1;
    cycle();
    drain();
    chk("post_rst_job", VW'(n_out - obase), VW'(1));
    chk("post_rst_done", VW'(done_hist[0]), VW'(1'b1));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
